// File: rtl/channel_accum.sv
// channel_accum: sums NUM_PARTS partial dot products per output channel,
// adds a per-channel bias, applies optional ReLU and saturates to `DATA_LEN bits.
`ifndef DATA_LEN
`define DATA_LEN 16
`endif

module channel_accum #(
  parameter int NUM_PARTS = 3,
  parameter int ACC_EXT   = 4,
  parameter bit RELU_EN   = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        in_valid,
  input  logic signed [`DATA_LEN-1:0] in_data,
  input  logic signed [`DATA_LEN-1:0] bias,
  output logic                        busy,
  output logic                        out_valid,
  output logic signed [`DATA_LEN-1:0] out_data
);

  localparam int DW = `DATA_LEN;
  localparam int AW = DW + ACC_EXT;
  localparam int CW = 4;

  localparam logic signed [AW-1:0] SAT_MAX = {{(ACC_EXT+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN = {{(ACC_EXT+1){1'b1}}, {(DW-1){1'b0}}};
  localparam logic [CW-1:0]        PARTS_LAST = CW'(NUM_PARTS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    BIAS  = 2'd2,
    OUT   = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic signed [AW-1:0]  acc_q, acc_d;
  logic [CW-1:0]         part_cnt_q, part_cnt_d;
  logic                  in_valid_dly_q, in_valid_dly_d;
  logic                  out_valid_q, out_valid_d;
  logic signed [DW-1:0]  out_data_q, out_data_d;

  logic                  accept;
  logic [CW-1:0]         part_cnt_inc;
  logic signed [AW-1:0]  in_ext;
  logic signed [AW-1:0]  bias_ext;
  logic signed [AW-1:0]  relu_val;
  logic signed [DW-1:0]  sat_val;

  // Only rising edges of the upstream level count as a new partial.
  assign accept       = in_valid & ~in_valid_dly_q;
  assign part_cnt_inc = part_cnt_q + CW'(1);
  assign in_ext       = {{ACC_EXT{in_data[DW-1]}}, in_data};
  assign bias_ext     = {{ACC_EXT{bias[DW-1]}}, bias};

  always_comb begin
    relu_val = acc_q;
    if (RELU_EN && acc_q[AW-1]) begin
      relu_val = '0;
    end
    if (relu_val > SAT_MAX) begin
      sat_val = SAT_MAX[DW-1:0];
    end else if (relu_val < SAT_MIN) begin
      sat_val = SAT_MIN[DW-1:0];
    end else begin
      sat_val = relu_val[DW-1:0];
    end
  end

  always_comb begin
    state_d        = state_q;
    acc_d          = acc_q;
    part_cnt_d     = part_cnt_q;
    in_valid_dly_d = in_valid;
    out_valid_d    = 1'b0;
    out_data_d     = out_data_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d      = '0;
          part_cnt_d = '0;
          state_d    = ACCUM;
        end
      end
      ACCUM: begin
        // A restart wins over an accept arriving in the same cycle.
        if (start) begin
          acc_d      = '0;
          part_cnt_d = '0;
        end else if (accept) begin
          acc_d      = acc_q + in_ext;
          part_cnt_d = part_cnt_inc;
          if (part_cnt_inc == PARTS_LAST) begin
            state_d = BIAS;
          end
        end
      end
      BIAS: begin
        acc_d   = acc_q + bias_ext;
        state_d = OUT;
      end
      OUT: begin
        out_data_d  = sat_val;
        out_valid_d = 1'b1;
        state_d     = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      acc_q          <= '0;
      part_cnt_q     <= '0;
      in_valid_dly_q <= 1'b0;
      out_valid_q    <= 1'b0;
      out_data_q     <= '0;
    end else begin
      state_q        <= state_d;
      acc_q          <= acc_d;
      part_cnt_q     <= part_cnt_d;
      in_valid_dly_q <= in_valid_dly_d;
      out_valid_q    <= out_valid_d;
      out_data_q     <= out_data_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule
